id_stage: RTL and testbench

Instruction decode stage of the MIPS datapath, directly upstream of the `alu` block. Accepts one 32-bit instruction per handshake, reads the 32×32 register file, and decodes the opcode/funct into the ALU's 4-bit `select` code. It builds operands `a`/`b`, with the immediate sign- or zero-extended or shifted as the instruction requires. Results sit in an ID/EX pipeline register that drives the ALU and the memory/writeback control of later stages.

---
 rtl/id_stage.sv | 209 ++++++++++++++++++++
 tb/tb_id_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// MIPS instruction decode stage: register file read, opcode/funct decode, ID/EX register.
// Optional ID_WB_BYPASS_EN: same-cycle writeback data replaces the register-file read.
module id_stage #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_select,
    output logic [DATA_W-1:0] store_data,
    output logic [4:0]        dest_reg,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch,
    output logic              illegal,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    localparam logic [3:0] SelAdd = 4'b0000;
    localparam logic [3:0] SelSub = 4'b0001;
    localparam logic [3:0] SelAnd = 4'b0110;
    localparam logic [3:0] SelOr  = 4'b0111;
    localparam logic [3:0] SelLui = 4'b1100;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    typedef enum logic {StEmpty, StFull} state_e;

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        unused_shamt;

    assign opcode       = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign imm          = instr[15:0];
    assign unused_shamt = ^instr[10:6];

    // Register file; entry 0 is never written so it always reads zero.
    logic [DATA_W-1:0] rf_q [32];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    always_comb begin
        rs_val = rf_q[rs];
        rt_val = rf_q[rt];
`ifdef ID_WB_BYPASS_EN
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == rs)) begin
            rs_val = wb_data;
        end
        if (wb_en && (wb_addr != 5'd0) && (wb_addr == rt)) begin
            rt_val = wb_data;
        end
`endif
    end

    // Decode
    logic              dec_legal;
    logic [3:0]        dec_sel;
    logic [DATA_W-1:0] dec_b;
    logic [4:0]        dec_dest;
    logic              dec_rw;
    logic              dec_mr;
    logic              dec_mw;
    logic              dec_br;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_high;

    assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zext = {{(DATA_W-16){1'b0}}, imm};
    assign imm_high = {imm, {(DATA_W-16){1'b0}}};

    always_comb begin
        dec_legal = 1'b1;
        dec_sel   = SelAdd;
        dec_b     = imm_sext;
        dec_dest  = rt;
        dec_rw    = 1'b1;
        dec_mr    = 1'b0;
        dec_mw    = 1'b0;
        dec_br    = 1'b0;
        unique case (opcode)
            OpRtype: begin
                dec_b    = rt_val;
                dec_dest = rd;
                unique case (funct)
                    6'h20, 6'h21: dec_sel = SelAdd;
                    6'h22, 6'h23: dec_sel = SelSub;
                    6'h24:        dec_sel = SelAnd;
                    6'h25:        dec_sel = SelOr;
                    default:      dec_legal = 1'b0;
                endcase
            end
            OpAddi, OpAddiu: dec_sel = SelAdd;
            OpAndi: begin
                dec_sel = SelAnd;
                dec_b   = imm_zext;
            end
            OpOri: begin
                dec_sel = SelOr;
                dec_b   = imm_zext;
            end
            OpLui: begin
                dec_sel = SelLui;
                dec_b   = imm_high;
            end
            OpLw: dec_mr = 1'b1;
            OpSw: begin
                dec_mw = 1'b1;
                dec_rw = 1'b0;
            end
            OpBeq: begin
                dec_sel = SelSub;
                dec_b   = rt_val;
                dec_br  = 1'b1;
                dec_rw  = 1'b0;
            end
            default: dec_legal = 1'b0;
        endcase
        // Writes to $0 are architecturally discarded.
        if (dec_dest == 5'd0) begin
            dec_rw = 1'b0;
        end
    end

    // ID/EX pipeline register
    state_e state_q;
    logic   accept;

    assign out_valid = (state_q == StFull);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StEmpty;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
            store_data <= '0;
            dest_reg   <= '0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            branch     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            illegal <= 1'b0;
            if (flush) begin
                state_q <= StEmpty;
            end else if (accept && dec_legal) begin
                state_q    <= StFull;
                alu_a      <= rs_val;
                alu_b      <= dec_b;
                alu_select <= dec_sel;
                store_data <= rt_val;
                dest_reg   <= dec_dest;
                reg_write  <= dec_rw;
                mem_read   <= dec_mr;
                mem_write  <= dec_mw;
                branch     <= dec_br;
            end else if (accept) begin
                // Illegal instruction becomes a bubble; any held entry was consumed.
                state_q <= StEmpty;
                illegal <= 1'b1;
            end else if (out_ready) begin
                state_q <= StEmpty;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios then randomized traffic
// checked against an instruction-level reference model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_select;
    logic [31:0] store_data;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    id_stage #(.DATA_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_select (alu_select),
        .store_data (store_data),
        .dest_reg   (dest_reg),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .branch     (branch),
        .illegal    (illegal),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        legal;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [3:0]  sel;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
    } dec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic        m_illegal;
    dec_t        m_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int fn);
        return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn);
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt,
                                          input int imm);
        return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (32'(imm) & 32'hFFFF);
    endfunction

    // Reference decode from the instruction table, using arithmetic extension.
    function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] rsv,
                                        input logic [31:0] rtv);
        dec_t        d;
        int          op;
        int          fn;
        int          imm;
        logic [31:0] sext;
        op   = int'(ins >> 26);
        fn   = int'(ins & 32'h3F);
        imm  = int'(ins & 32'hFFFF);
        sext = (imm >= 32768) ? 32'(imm - 65536) : 32'(imm);
        d       = '0;
        d.legal = 1'b1;
        d.a     = rsv;
        d.sd    = rtv;
        d.rw    = 1'b1;
        d.dest  = 5'((ins >> 16) & 32'h1F);
        d.b     = sext;
        case (op)
            0: begin
                d.b    = rtv;
                d.dest = 5'((ins >> 11) & 32'h1F);
                if (fn == 32 || fn == 33) d.sel = 4'd0;
                else if (fn == 34 || fn == 35) d.sel = 4'd1;
                else if (fn == 36) d.sel = 4'd6;
                else if (fn == 37) d.sel = 4'd7;
                else d.legal = 1'b0;
            end
            8, 9: d.sel = 4'd0;
            12: begin d.sel = 4'd6; d.b = 32'(imm); end
            13: begin d.sel = 4'd7; d.b = 32'(imm); end
            15: begin d.sel = 4'd12; d.b = 32'(imm) * 32'd65536; end
            35: d.mr = 1'b1;
            43: begin d.mw = 1'b1; d.rw = 1'b0; end
            4: begin d.sel = 4'd1; d.b = rtv; d.br = 1'b1; d.rw = 1'b0; end
            default: d.legal = 1'b0;
        endcase
        if (d.dest == 5'd0) d.rw = 1'b0;
        return d;
    endfunction

    function automatic logic [31:0] ref_read(input int r, input logic we, input logic [4:0] wa,
                                             input logic [31:0] wd);
        logic [31:0] v;
        v = (r == 0) ? 32'd0 : m_rf[r];
`ifdef ID_WB_BYPASS_EN
        if (we && wa != 5'd0 && int'(wa) == r) v = wd;
`endif
        return v;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("illegal", 32'(illegal), 32'(m_illegal));
        if (m_valid) begin
            chk("alu_a", alu_a, m_out.a);
            chk("alu_b", alu_b, m_out.b);
            chk("alu_select", 32'(alu_select), 32'(m_out.sel));
            chk("store_data", store_data, m_out.sd);
            chk("dest_reg", 32'(dest_reg), 32'(m_out.dest));
            chk("reg_write", 32'(reg_write), 32'(m_out.rw));
            chk("mem_read", 32'(mem_read), 32'(m_out.mr));
            chk("mem_write", 32'(mem_write), 32'(m_out.mw));
            chk("branch", 32'(branch), 32'(m_out.br));
        end
    endtask

    // One clock cycle: drive, check in_ready, advance model, check outputs after the edge.
    task automatic cyc(input logic iv, input logic [31:0] ins, input logic fl, input logic ordy,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic acc;
        dec_t d;
        in_valid  = iv;
        instr     = ins;
        flush     = fl;
        out_ready = ordy;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
        acc = iv && (!m_valid || ordy);
        d = ref_decode(ins, ref_read(int'((ins >> 21) & 32'h1F), we, wa, wd),
                       ref_read(int'((ins >> 16) & 32'h1F), we, wa, wd));
        @(posedge clk);
        #1;
        m_illegal = 1'b0;
        if (fl) begin
            m_valid = 1'b0;
        end else if (acc && d.legal) begin
            m_valid = 1'b1;
            m_out   = d;
        end else if (acc) begin
            m_valid   = 1'b0;
            m_illegal = 1'b1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        if (we && wa != 5'd0) m_rf[wa] = wd;
        check_outputs();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_valid   = 1'b0;
        m_illegal = 1'b0;
        m_out     = '0;
    endtask

    function automatic logic [31:0] rand_instr();
        int fns [6] = '{32, 33, 34, 35, 36, 37};
        int ops [8] = '{8, 9, 12, 13, 15, 35, 43, 4};
        int rs;
        int rt;
        int rd;
        int k;
        rs = int'($urandom_range(0, 7));
        rt = int'($urandom_range(0, 7));
        rd = int'($urandom_range(0, 7));
        k  = int'($urandom_range(0, 19));
        if (k < 7) return rtype(rs, rt, rd, fns[$urandom_range(0, 5)]);
        if (k < 18) return itype(ops[$urandom_range(0, 7)], rs, rt, int'($urandom_range(0, 65535)));
        if (k == 18) return rtype(rs, rt, rd, 6'h26);
        return itype(6'h3F, rs, rt, int'($urandom_range(0, 65535)));
    endfunction

    initial begin
        logic [31:0] ins;
        reset_n = 1'b0;
        in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset alu_a", alu_a, 32'd0);
        chk("reset alu_b", alu_b, 32'd0);
        chk("reset select", 32'(alu_select), 32'd0);
        chk("reset ctrl", 32'({out_valid, reg_write, mem_read, mem_write, branch, illegal}),
            32'd0);

        // addi $1,$0,-5
        cyc(1, 32'h2001FFFB, 0, 1, 0, 0, 0);
        chk("addi alu_b", alu_b, 32'hFFFFFFFB);
        chk("addi dest", 32'(dest_reg), 32'd1);
        chk("addi reg_write", 32'(reg_write), 32'd1);

        cyc(0, 0, 0, 1, 1, 2, 32'h12345678);
        cyc(1, rtype(2, 2, 3, 34), 0, 1, 0, 0, 0);
        chk("sub alu_a", alu_a, 32'h12345678);
        chk("sub select", 32'(alu_select), 32'd1);

        cyc(1, itype(15, 0, 4, 16'hABCD), 0, 1, 0, 0, 0);
        chk("lui alu_b", alu_b, 32'hABCD0000);
        cyc(1, itype(13, 4, 4, 16'h8001), 0, 1, 0, 0, 0);
        chk("ori alu_b", alu_b, 32'h00008001);

        // Back-pressure: hold three cycles, then drain back-to-back.
        cyc(1, itype(8, 1, 7, 100), 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, itype(9, 2, 8, i), 0, 0, 1, 9, 32'd55);
        for (int i = 0; i < 4; i++) cyc(1, rtype(i, 9, 10 + i, 37), 0, 1, 0, 0, 0);

        // Illegal op, then flush against a legal accept and against a hold.
        cyc(1, itype(6'h3F, 1, 2, 3), 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(1, itype(8, 0, 11, 1), 1, 1, 0, 0, 0);
        cyc(1, itype(8, 0, 11, 1), 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 12, 32'd3);
        cyc(1, itype(6'h3F, 1, 2, 3), 1, 1, 0, 0, 0);

        // Same-cycle writeback and read of $5.
        cyc(1, rtype(5, 0, 6, 32), 0, 1, 1, 5, 32'd7);
        cyc(1, rtype(5, 0, 6, 32), 0, 1, 0, 0, 0);

        for (int i = 0; i < 500; i++) begin
            ins = rand_instr();
            cyc($urandom_range(0, 3) != 0, ins, $urandom_range(0, 19) == 0,
                $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 7)), $urandom());
        end

        // Asynchronous reset while holding an instruction.
        cyc(1, itype(8, 3, 4, 9), 0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset alu_b", alu_b, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1, rtype(3, 4, 5, 33), 0, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
